piso_framer: RTL and testbench

PISO_FRAMER -- requirements
Module: piso_framer

---
 rtl/piso_framer_pkg.sv | 18 +
 rtl/piso_framer_bit_timer.sv | 44 ++++
 rtl/piso_framer.sv | 142 ++++++++++++++
 tb/tb_piso_framer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/piso_framer_pkg.sv
// Shared types and helpers for the parallel-in serial-out framer.
// Holds the frame FSM state encoding and the frame-length calculation.
package piso_framer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  // Total clock cycles one frame occupies on the serial line.
  function automatic int frame_len(input int data_w, input int parity_en, input int bit_cycles);
    return (2 + data_w + parity_en) * bit_cycles;
  endfunction

endpackage

// File: rtl/piso_framer_bit_timer.sv
// Bit-period counter: counts BIT_CYCLES clocks per serial bit and strobes the last one.
// bit_end_next looks one cycle ahead so the parent can register a last-cycle pulse.
module bit_timer
  import piso_framer_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_end,
  output logic bit_end_next
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end      = (cnt_q == CNT_MAX);
  assign bit_end_next = (cnt_d == CNT_MAX);

endmodule

// File: rtl/piso_framer.sv
// Serialises parallel words as start bit, LSB-first data, optional even parity, stop bit.
// All outputs come straight from flops; next-cycle values are computed from the next state.
module piso_framer
  import piso_framer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int BIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              serial_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              parity_q, parity_d;
  logic              serial_q, serial_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic handshake;
  logic bit_end;
  logic bit_end_next;

  assign handshake = data_valid & ready_q;

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clock       (clock),
    .reset       (reset),
    .clear       (handshake),
    .enable      (state_q != IDLE),
    .bit_end     (bit_end),
    .bit_end_next(bit_end_next)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    parity_d = parity_q;
    serial_d = serial_q;

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        if (handshake) begin
          shreg_d  = data_in;
          parity_d = ^data_in;
          state_d  = START;
          serial_d = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d  = DATA;
          idx_d    = '0;
          serial_d = shreg_q[0];
          shreg_d  = shreg_q >> 1;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            if (PARITY_EN != 0) begin
              state_d  = PARITY;
              serial_d = parity_q;
            end else begin
              state_d  = STOP;
              serial_d = 1'b1;
            end
          end else begin
            idx_d    = idx_q + 1'b1;
            serial_d = shreg_q[0];
            shreg_d  = shreg_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d  = STOP;
          serial_d = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d  = IDLE;
          serial_d = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    // Pulse lands on the cycle whose counter value is the last of the stop bit.
    done_d  = (state_d == STOP) && bit_end_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
      serial_q <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign data_ready = ready_q;
  assign serial_out = serial_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_piso_framer.sv
// Bench for piso_framer: two configurations, directed and random frames against a bit-list model.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_piso_framer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] din_a, din_b;
  logic       val_a, val_b;
  logic       rdy_a, ser_a, busy_a, done_a;
  logic       rdy_b, ser_b, busy_b, done_b;
  logic [3:0] sr;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];

  piso_framer #(.DATA_W(8), .PARITY_EN(1), .BIT_CYCLES(1)) dut_a (
    .clock(clock), .reset(reset), .data_in(din_a), .data_valid(val_a),
    .data_ready(rdy_a), .serial_out(ser_a), .busy(busy_a), .frame_done(done_a)
  );

  piso_framer #(.DATA_W(8), .PARITY_EN(0), .BIT_CYCLES(3)) dut_b (
    .clock(clock), .reset(reset), .data_in(din_b), .data_valid(val_b),
    .data_ready(rdy_b), .serial_out(ser_b), .busy(busy_b), .frame_done(done_b)
  );

  always #5 clock = ~clock;

  // Downstream 4-stage reset-to-zero shift register fed by dut_a.
  always @(posedge clock) begin
    if (reset) sr <= '0;
    else       sr <= {sr[2:0], ser_a};
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame as a list of line bits, each repeated for its bit period.
  function automatic void build_frame(input logic [7:0] w, input int pe, input int bc);
    bit bits[$];
    bit p;
    p = 1'b0;
    exp_q.delete();
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(w[i]);
      p ^= w[i];
    end
    if (pe != 0) bits.push_back(p);
    bits.push_back(1'b1);
    foreach (bits[i]) for (int c = 0; c < bc; c++) exp_q.push_back(bits[i]);
  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin val_a = v; din_a = d; end
    else          begin val_b = v; din_b = d; end
  endtask

  task automatic read(input int sel, output logic s, output logic d, output logic b, output logic r);
    if (sel == 0) begin s = ser_a; d = done_a; b = busy_a; r = rdy_a; end
    else          begin s = ser_b; d = done_b; b = busy_b; r = rdy_b; end
  endtask

  task automatic check_idle(input int sel, input string tag);
    logic s, d, b, r;
    read(sel, s, d, b, r);
    check({tag, " serial"}, s, 1'b1);
    check({tag, " frame_done"}, d, 1'b0);
    check({tag, " busy"}, b, 1'b0);
    check({tag, " data_ready"}, r, 1'b1);
  endtask

  // Called in an idle cycle; returns in the idle cycle after the frame (or after an abort).
  task automatic run_frame(input int sel, input logic [7:0] w, input bit hold_valid, input int abort_at);
    int n;
    logic s, d, b, r;
    build_frame(w, (sel == 0) ? 1 : 0, (sel == 0) ? 1 : 3);
    n = exp_q.size();
    check("hs_ready", (sel == 0) ? rdy_a : rdy_b, 1'b1);
    drive(sel, 1'b1, w);
    for (int k = 1; k <= n; k++) begin
      @(posedge clock); #1;
      drive(sel, hold_valid, 8'($urandom));
      read(sel, s, d, b, r);
      check($sformatf("serial w=%02h c%0d", w, k), s, exp_q[k-1]);
      check($sformatf("frame_done c%0d", k), d, (k == n));
      check($sformatf("busy c%0d", k), b, 1'b1);
      check($sformatf("data_ready c%0d", k), r, 1'b0);
      if (sel == 0 && k >= 5) check($sformatf("chain c%0d", k), sr[3], exp_q[k-5]);
      if (k == abort_at) begin
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        drive(sel, 1'b0, 8'($urandom));
        check_idle(sel, "abort");
        return;
      end
    end
    @(posedge clock); #1;
    check_idle(sel, $sformatf("post w=%02h", w));
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (2) @(posedge clock);
    #1;
    check_idle(0, "reset a");
    check_idle(1, "reset b");
    reset = 1'b0;
    @(posedge clock); #1;

    // Reference frame and the downstream shift register tail.
    run_frame(0, 8'hA5, 1'b0, 0);
    check("chain c12", sr[3], exp_q[7]);
    for (int j = 8; j <= 10; j++) begin
      @(posedge clock); #1;
      check($sformatf("chain tail %0d", j), sr[3], exp_q[j]);
    end

    run_frame(0, 8'h07, 1'b0, 0);
    run_frame(1, 8'h01, 1'b0, 0);

    // Back-to-back frames with data_valid held high and data_in changing every cycle.
    for (int i = 0; i < 4; i++) run_frame(0, 8'($urandom), 1'b1, 0);
    drive(0, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) run_frame(1, 8'($urandom), 1'b1, 0);
    drive(1, 1'b0, 8'h00);
    @(posedge clock); #1;

    // Abort mid-frame, then confirm recovery.
    run_frame(0, 8'hFF, 1'b0, 5);
    @(posedge clock); #1;
    check_idle(0, "after abort");
    run_frame(0, 8'h3C, 1'b0, 0);

    // Reset beats a simultaneous handshake.
    drive(0, 1'b1, 8'h5A);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    drive(0, 1'b0, 8'h00);
    check_idle(0, "rst_vs_hs");
    @(posedge clock); #1;
    check_idle(0, "rst_vs_hs next");

    for (int i = 0; i < 8; i++) begin
      run_frame(int'($urandom_range(0, 1)), 8'($urandom), 1'b0, 0);
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
